// File: rtl/prog_mem_loader_pkg.sv
// Shared types and sizing helpers for the loadable program memory.
package prog_mem_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;
    localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    // Number of byte lanes in a word of the given width.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a counter that indexes the byte lanes (at least one bit).
    function automatic int byte_cnt_width(input int data_w);
        return ((data_w / 8) > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_loader_byte_word_packer.sv
// Assembles a little-endian byte stream into memory words and reports
// when a full word is ready or when a partial word must be flushed.
module byte_word_packer
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    input  logic              clear_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_done_o,
    output logic              flush_o
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = byte_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next lane contents and byte counter; clear wins over a new byte.
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        for (int i = 0; i < BPW; i++) begin
            if (accept_i && (CNT_W'(i) == cnt_q)) begin
                asm_d[i*8 +: 8] = byte_i;
            end
        end
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            cnt_d = (cnt_q == LAST_LANE) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Word to write: filled lanes, the incoming byte, zeros above it.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < BPW; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                word_o[i*8 +: 8] = asm_q[i*8 +: 8];
            end else if (accept_i && (CNT_W'(i) == cnt_q)) begin
                word_o[i*8 +: 8] = byte_i;
            end
        end
        word_done_o = accept_i && (cnt_q == LAST_LANE) && !flush_i;
        flush_o     = flush_i && ((cnt_q != '0) || accept_i);
    end

    // Assembly register and lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Loadable instruction memory: registered fetch port in RUN, byte-stream
// loader in LOAD, with the datapath stalled while loading.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              load_end,
    output logic              load_busy,
    output logic              load_overflow,
    output logic [ADDR_W:0]   load_words
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            st_q, st_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;

    logic              accept;
    logic              pk_clear;
    logic              pk_flush;
    logic [DATA_W-1:0] pk_word;
    logic              pk_word_done;
    logic              pk_flush_w;
    logic              write_req;
    logic              room;
    logic              mem_we;

    assign load_busy     = (st_q == ST_LOAD);
    assign load_ready    = load_busy && !overflow_q;
    assign load_overflow = overflow_q;
    assign load_words    = ptr_q;
    assign fetch_data    = fetch_data_q;
    assign fetch_valid   = fetch_valid_q;

    // A byte arriving with load_start is discarded by the restart.
    assign accept    = load_valid && load_ready && !load_start;
    assign pk_clear  = load_start || load_end;
    assign pk_flush  = load_busy && load_end && !load_start;
    assign write_req = pk_word_done || pk_flush_w;
    assign room      = (ptr_q < DEPTH_L);
    assign mem_we    = write_req && room;

    byte_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .accept_i    (accept),
        .byte_i      (load_byte),
        .clear_i     (pk_clear),
        .flush_i     (pk_flush),
        .word_o      (pk_word),
        .word_done_o (pk_word_done),
        .flush_o     (pk_flush_w)
    );

    // Controller next state, load pointer and sticky overflow.
    always_comb begin
        st_d       = st_q;
        ptr_d      = ptr_q;
        overflow_d = overflow_q;
        if (write_req) begin
            if (room) begin
                ptr_d = ptr_q + (ADDR_W + 1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (load_start) begin
            ptr_d      = '0;
            overflow_d = 1'b0;
        end
        case (st_q)
            ST_RUN: begin
                if (load_start && !load_end) begin
                    st_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_end) begin
                    st_d = ST_RUN;
                end
            end
            default: st_d = ST_RUN;
        endcase
    end

    // Fetch port: serve reads only in RUN, hold data otherwise.
    always_comb begin
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        if ((st_q == ST_RUN) && fetch_en) begin
            fetch_valid_d = 1'b1;
            if ({1'b0, fetch_addr} < DEPTH_L) begin
                fetch_data_d = mem[fetch_addr[IDX_W-1:0]];
            end else begin
                fetch_data_d = '0;
            end
        end
    end

    // Control and fetch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= ST_RUN;
            ptr_q         <= '0;
            overflow_q    <= 1'b0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            st_q          <= st_d;
            ptr_q         <= ptr_d;
            overflow_q    <= overflow_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[IDX_W-1:0]] <= pk_word;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader using a small 4-word memory.
module tb_prog_mem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_end;
    logic              load_busy;
    logic              load_overflow;
    logic [ADDR_W:0]   load_words;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic        rst;
        logic        fe;
        logic [2:0]  fa;
        logic        ls;
        logic        lv;
        logic [7:0]  lb;
        logic        le;
        logic        expFv;
        logic [31:0] expFd;
        logic        expBusy;
        logic        expReady;
        logic        expOv;
        logic [3:0]  expWords;
    } vec_t;

    vec_t vecs [19];

    prog_mem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .fetch_data    (fetch_data),
        .fetch_valid   (fetch_valid),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_ready    (load_ready),
        .load_end      (load_end),
        .load_busy     (load_busy),
        .load_overflow (load_overflow),
        .load_words    (load_words)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the run ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic r, input logic fe, input logic [2:0] fa,
                                input logic ls, input logic lv, input logic [7:0] lb,
                                input logic le, input logic efv, input logic [31:0] efd,
                                input logic eb, input logic er, input logic eo,
                                input logic [3:0] ew);
        vec_t v;
        v.rst = r; v.fe = fe; v.fa = fa; v.ls = ls; v.lv = lv; v.lb = lb; v.le = le;
        v.expFv = efv; v.expFd = efd; v.expBusy = eb; v.expReady = er;
        v.expOv = eo; v.expWords = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        fetch_en   = v.fe;
        fetch_addr = v.fa;
        load_start = v.ls;
        load_valid = v.lv;
        load_byte  = v.lb;
        load_end   = v.le;
        tick();
        rst = 0; fetch_en = 0; load_start = 0; load_valid = 0; load_end = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulseEnd();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic doFetch(input string name, input logic [2:0] addr,
                           input logic [31:0] expected);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_en = 1'b0;
        checkOutput({name, " valid"}, 64'(fetch_valid), 64'd1);
        checkOutput({name, " data"}, 64'(fetch_data), 64'(expected));
    endtask

    initial begin
        logic [7:0]  bpBytes [8];
        logic [31:0] heldData;
        logic [31:0] word;
        int          idx;
        int          cycles;
        logic        v;

        testsRun = 0; testsFailed = 0;
        rst = 0; fetch_en = 0; fetch_addr = '0; load_start = 0;
        load_valid = 0; load_byte = '0; load_end = 0;

        vecs[0]  = mk(T, F, 3'd0, F, F, 8'h00, F, F, 32'h0, F, F, F, 4'd0);
        vecs[1]  = mk(T, F, 3'd0, F, F, 8'h00, F, F, 32'h0, F, F, F, 4'd0);
        vecs[2]  = mk(F, T, 3'd0, F, F, 8'h00, F, T, 32'h0, F, F, F, 4'd0);
        vecs[3]  = mk(F, T, 3'd5, F, F, 8'h00, F, T, 32'h0, F, F, F, 4'd0);
        vecs[4]  = mk(F, F, 3'd0, F, F, 8'h00, F, F, 32'h0, F, F, F, 4'd0);
        vecs[5]  = mk(F, F, 3'd0, T, F, 8'h00, F, F, 32'h0, T, T, F, 4'd0);
        vecs[6]  = mk(F, F, 3'd0, F, T, 8'h13, F, F, 32'h0, T, T, F, 4'd0);
        vecs[7]  = mk(F, F, 3'd0, F, T, 8'h07, F, F, 32'h0, T, T, F, 4'd0);
        vecs[8]  = mk(F, F, 3'd0, F, T, 8'h00, F, F, 32'h0, T, T, F, 4'd0);
        vecs[9]  = mk(F, F, 3'd0, F, T, 8'h03, F, F, 32'h0, T, T, F, 4'd1);
        vecs[10] = mk(F, F, 3'd0, F, T, 8'h93, F, F, 32'h0, T, T, F, 4'd1);
        vecs[11] = mk(F, F, 3'd0, F, T, 8'h05, F, F, 32'h0, T, T, F, 4'd1);
        vecs[12] = mk(F, F, 3'd0, F, T, 8'h00, F, F, 32'h0, T, T, F, 4'd1);
        vecs[13] = mk(F, F, 3'd0, F, T, 8'h00, F, F, 32'h0, T, T, F, 4'd2);
        vecs[14] = mk(F, F, 3'd0, F, F, 8'h00, T, F, 32'h0, F, F, F, 4'd2);
        vecs[15] = mk(F, T, 3'd0, F, F, 8'h00, F, T, 32'h03000713, F, F, F, 4'd2);
        vecs[16] = mk(F, T, 3'd1, F, F, 8'h00, F, T, 32'h00000593, F, F, F, 4'd2);
        vecs[17] = mk(F, F, 3'd0, F, F, 8'h00, F, F, 32'h00000593, F, F, F, 4'd2);
        vecs[18] = mk(F, T, 3'd7, F, F, 8'h00, F, T, 32'h0, F, F, F, 4'd2);

        // Reset, first fetches and basic load/fetch.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d fetch_valid", i), 64'(fetch_valid), 64'(vecs[i].expFv));
            checkOutput($sformatf("vec%0d fetch_data", i), 64'(fetch_data), 64'(vecs[i].expFd));
            checkOutput($sformatf("vec%0d load_busy", i), 64'(load_busy), 64'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d load_ready", i), 64'(load_ready), 64'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d load_overflow", i), 64'(load_overflow), 64'(vecs[i].expOv));
            checkOutput($sformatf("vec%0d load_words", i), 64'(load_words), 64'(vecs[i].expWords));
        end

        // Partial flush with a byte accepted on the load_end cycle.
        pulseStart();
        sendByte(8'h73); sendByte(8'h00); sendByte(8'h00);
        load_valid = 1'b1; load_byte = 8'h00; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        checkOutput("flushA busy", 64'(load_busy), 64'd0);
        checkOutput("flushA words", 64'(load_words), 64'd1);
        doFetch("flushA mem0", 3'd0, 32'h00000073);

        // Full word then a two-byte partial word.
        pulseStart();
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        sendByte(8'hAA); sendByte(8'hBB);
        pulseEnd();
        checkOutput("flushB words", 64'(load_words), 64'd2);
        doFetch("flushB mem0", 3'd0, 32'h44332211);
        doFetch("flushB mem1", 3'd1, 32'h0000BBAA);

        // load_end on a word boundary writes nothing extra.
        pulseStart();
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
        pulseEnd();
        checkOutput("noflush words", 64'(load_words), 64'd1);
        doFetch("noflush mem0", 3'd0, 32'h04030201);
        doFetch("noflush mem1", 3'd1, 32'h0000BBAA);

        // Backpressure on load_valid while fetches are requested.
        bpBytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        heldData = fetch_data;
        pulseStart();
        idx = 0;
        cycles = 0;
        while (idx < 8 && cycles < 200) begin
            v = 1'($urandom_range(0, 1));
            load_valid = v;
            load_byte  = v ? bpBytes[idx] : 8'hEE;
            fetch_en   = 1'b1;
            fetch_addr = 3'd0;
            tick();
            if (v) idx++;
            cycles++;
            checkOutput("stall fetch_valid", 64'(fetch_valid), 64'd0);
            checkOutput("stall fetch_data", 64'(fetch_data), 64'(heldData));
        end
        load_valid = 1'b0;
        fetch_en   = 1'b0;
        checkOutput("backpressure budget", 64'(idx), 64'd8);
        pulseEnd();
        checkOutput("bp words", 64'(load_words), 64'd2);
        doFetch("bp mem0", 3'd0, 32'hEFBEADDE);
        doFetch("bp mem1", 3'd1, 32'h67452301);

        // Overflow: five words into a four-word memory.
        pulseStart();
        for (int k = 0; k < 16; k++) sendByte(8'(8'h10 + k));
        checkOutput("ovf words4", 64'(load_words), 64'd4);
        checkOutput("ovf ready before", 64'(load_ready), 64'd1);
        checkOutput("ovf flag before", 64'(load_overflow), 64'd0);
        for (int k = 16; k < 20; k++) sendByte(8'(8'h10 + k));
        checkOutput("ovf flag", 64'(load_overflow), 64'd1);
        checkOutput("ovf ready", 64'(load_ready), 64'd0);
        checkOutput("ovf words", 64'(load_words), 64'd4);
        sendByte(8'h99);
        checkOutput("ovf words held", 64'(load_words), 64'd4);
        pulseEnd();
        checkOutput("ovf busy after end", 64'(load_busy), 64'd0);
        checkOutput("ovf sticky after end", 64'(load_overflow), 64'd1);
        for (int j = 0; j < 4; j++) begin
            word = {8'(8'h13 + 4*j), 8'(8'h12 + 4*j), 8'(8'h11 + 4*j), 8'(8'h10 + 4*j)};
            doFetch($sformatf("ovf mem%0d", j), 3'(j), word);
        end
        pulseStart();
        checkOutput("restart clears ovf", 64'(load_overflow), 64'd0);
        checkOutput("restart ready", 64'(load_ready), 64'd1);
        checkOutput("restart words", 64'(load_words), 64'd0);
        pulseEnd();

        // Reset in the middle of a load.
        pulseStart();
        for (int k = 0; k < 6; k++) sendByte(8'(8'hA0 + k));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst busy", 64'(load_busy), 64'd0);
        checkOutput("midrst words", 64'(load_words), 64'd0);
        checkOutput("midrst ready", 64'(load_ready), 64'd0);
        checkOutput("midrst overflow", 64'(load_overflow), 64'd0);
        checkOutput("midrst fetch_valid", 64'(fetch_valid), 64'd0);
        doFetch("midrst mem0", 3'd0, 32'hA3A2A1A0);
        doFetch("midrst mem1", 3'd1, 32'h17161514);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised synchronous instruction memory for the single-cycle RISC-V core. It is the successor to the fixed, combinational, hard-coded program ROM. It provides:
- a registered word-fetch port for the datapath;
- a byte-stream load port with valid/ready handshake, so programs can be written at run time without rebuilding the design.

A two-state controller arbitrates between the two ports: RUN serves fetches, LOAD accepts bytes. The datapath is stalled while loading.

## Interface
- DATA_W, 32: instruction word width; must be a multiple of 8.
- ADDR_W, 10: word-address width.
- DEPTH, 1024: number of words implemented; DEPTH ≤ 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  word address.
- fetch_data  out  DATA_W  registered read data.
- fetch_valid  out  1  fetch_data holds the result of the previous cycle's request.
- load_start  in  1  enter LOAD and clear load pointer/byte counter.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  next program byte, little-endian within word.
- load_ready  out  1  byte accepted when load_valid && load_ready.
- load_end  in  1  terminate load; flush any partial word.
- load_busy  out  1  controller is in LOAD.
- load_overflow  out  1  sticky; a full word was attempted at pointer == DEPTH.
- load_words  out  ADDR_W+1  words written in the current/last load.

## Operation
- States: RUN (reset state) and LOAD.
  - RUN→LOAD on load_start.
  - LOAD→RUN on load_end.
  - load_start in LOAD re-clears the pointer, byte counter and overflow, and stays in LOAD.
  - load_start and load_end together: load_end wins; the pointer and counter are cleared, with no flush.
- RUN behaviour:
  - fetch_en=1 registers mem[fetch_addr] into fetch_data; fetch_valid=1 next cycle.
  - fetch_en=0: fetch_valid=0 next cycle and fetch_data holds.
  - fetch_addr ≥ DEPTH returns 0.
- LOAD, fetch side: fetch_en is ignored; fetch_valid=0; fetch_data holds.
- LOAD, byte assembly:
  - An accepted byte goes into lane byte_cnt of the assembly register; byte_cnt increments.
  - When the last lane (DATA_W/8−1) is accepted, the full word (incoming byte included) is written to mem[ptr] on that same edge.
  - On that edge ptr and load_words increment and byte_cnt returns to 0.
- Overflow:
  - A full word with ptr == DEPTH is not written and sets load_overflow.
  - load_ready=0 from then until load_start or reset.
- load_end flush:
  - If byte_cnt ≠ 0, or a byte is accepted in the same cycle, the partial word is zero-padded in the upper lanes and written to mem[ptr] on that edge.
  - The same byte/overflow rules apply.
  - With byte_cnt=0 and no byte accepted, nothing is written.
- load_ready = load_busy && !load_overflow.
- Memory contents are not cleared by rst.
- Initial contents are 0; a simulation-only init file may preload them.

## Timing
- Reset values: fetch_data=0, fetch_valid=0, load_ready=0, load_busy=0, load_overflow=0, load_words=0. Internal ptr and byte_cnt are 0; state is RUN.
- Reset mid-load aborts the load and discards the partial word. Words already written remain in memory.
- Fetch latency is 1 cycle: address in cycle N, data and fetch_valid in cycle N+1.
- Throughput is one fetch per cycle and one byte per cycle.
- load_busy rises the cycle after load_start and falls the cycle after load_end.
- A fetch issued in the first RUN cycle after load_end sees the flushed word.
- No read/write collision is possible: fetches are blocked while writes occur.

## Structure
- Package prog_mem_pkg holds:
  - the state enum {ST_RUN, ST_LOAD};
  - the localparam BYTES_PER_WORD = DATA_W/8;
  - the byte-counter width $clog2(BYTES_PER_WORD).
- Sub-module byte_word_packer (assembly register, byte_cnt, word_done/flush outputs).
- The top level holds the FSM, pointer, memory array and fetch register.

## Test plan
- Reset then fetch: rst for 2 cycles, then fetch_en with addr 0 → fetch_valid=1 next cycle, fetch_data=0x00000000, all load outputs 0.
- Basic load and fetch:
  - stimulus: load_start; bytes 13 07 00 03 93 05 00 00, one per cycle; then load_end;
  - response: load_words=2;
  - fetch 0 → 0x03000713; fetch 1 → 0x00000593.
- Partial flush with simultaneous byte: 3 bytes 73 00 00, then load_end asserted together with byte 00 → load_words=1, mem[0]=0x00000073. Load 2 bytes AA BB then load_end → mem[next]=0x0000BBAA.
- Backpressure and stall:
  - load_valid toggles randomly → only handshaken bytes are assembled;
  - fetch_en during LOAD → fetch_valid stays 0 and fetch_data is unchanged.
- Overflow: DEPTH=4; load 5 words → load_overflow=1 and load_ready=0 after the 5th word; mem[0..3] intact; load_words=4.
- Reset mid-load: after 6 bytes, assert rst → load_busy=0, load_words=0, mem[0] written, mem[1] unchanged.
